// File: rtl/draw_pkg.sv
// draw_pkg: shared state encoding and constants for the square-drawing control path
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        DRAW,
        DONE
    } draw_state_t;

    localparam int SQUARE_CYCLES = 16;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;

endpackage

// File: rtl/draw_control.sv
// draw_control: sequences x/y/colour loads into the square datapath, then plots one 4x4 sweep
module draw_control
    import draw_pkg::*;
#(
    parameter int COORD_W       = 7,
    parameter int COLOUR_W      = 3,
    parameter int SQUARE_CYCLES = draw_pkg::SQUARE_CYCLES
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                go,
    input  logic [COORD_W-1:0]  x_in,
    input  logic [COORD_W-1:0]  y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                erase,
    output logic                busy,
    output logic                done,
    output logic                ld_x,
    output logic                ld_y,
    output logic                ld_colour,
    output logic [COORD_W-1:0]  coordinate,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot
);

    localparam int CNT_W = $clog2(SQUARE_CYCLES);

    draw_state_t         state;
    draw_state_t         state_next;
    logic [CNT_W-1:0]    cnt;
    logic [COORD_W-1:0]  x_cap;
    logic [COORD_W-1:0]  y_cap;
    logic [COLOUR_W-1:0] colour_cap;

    // State register; reset returns to IDLE so all Moore outputs drop at once
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Request capture in IDLE only, so later input changes cannot disturb a square in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_cap      <= '0;
            y_cap      <= '0;
            colour_cap <= '0;
        end else if (state == IDLE && go) begin
            x_cap      <= x_in;
            y_cap      <= y_in;
            colour_cap <= erase ? COLOUR_W'(COLOUR_BLACK) : colour_in;
        end
    end

    // Sweep counter: cleared while loading y, then counts the plot cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               cnt <= '0;
        else if (state == LOAD_Y)  cnt <= '0;
        else if (state == DRAW)    cnt <= cnt + 1'b1;
    end

    // Next-state and Moore output decode
    always_comb begin
        state_next = state;
        busy       = state != IDLE;
        done       = state == DONE;
        ld_x       = state == LOAD_X;
        ld_y       = state == LOAD_Y;
        ld_colour  = state == LOAD_Y;
        plot       = state == DRAW;
        coordinate = ld_x ? x_cap : (ld_y || plot) ? y_cap : '0;
        colour_out = (ld_y || plot) ? colour_cap : '0;
        case (state)
            IDLE:    state_next = go ? LOAD_X : IDLE;
            LOAD_X:  state_next = LOAD_Y;
            LOAD_Y:  state_next = DRAW;
            DRAW:    state_next = (cnt == CNT_W'(SQUARE_CYCLES - 1)) ? DONE : DRAW;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_draw_control.sv
// tb_draw_control: directed checks of draw_control against a free-running square datapath model
module tb_draw_control;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic [6:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [2:0] colour_in = '0;
    logic       erase = 1'b0;
    logic       busy, done, ld_x, ld_y, ld_colour, plot;
    logic [6:0] coordinate;
    logic [2:0] colour_out;

    int tests = 0;
    int fails = 0;

    // datapath model state
    logic [3:0] off = '0;
    logic [6:0] dx = '0, dy = '0;
    logic [2:0] dc = '0;
    logic [6:0] ex, ey;
    logic [2:0] ecol;
    int hits [16];
    int stray = 0;
    int pix_bad = 0;

    draw_control dut (
        .clk(clk), .resetn(resetn), .go(go), .x_in(x_in), .y_in(y_in),
        .colour_in(colour_in), .erase(erase), .busy(busy), .done(done),
        .ld_x(ld_x), .ld_y(ld_y), .ld_colour(ld_colour),
        .coordinate(coordinate), .colour_out(colour_out), .plot(plot)
    );

    always #5 clk = ~clk;

    // square datapath model: free-running offset, loads on strobes, records plotted pixels
    always @(posedge clk) begin
        logic [7:0] px, py;
        px = 8'(dx) + 8'(off[1:0]);
        py = 8'(dy) + 8'(off[3:2]);
        if (plot) begin
            if (px >= 8'(ex) && px < 8'(ex) + 8'd4 && py >= 8'(ey) && py < 8'(ey) + 8'd4) begin
                hits[(py - 8'(ey)) * 4 + (px - 8'(ex))]++;
                if (dc != ecol) pix_bad++;
            end else stray++;
        end
        if (ld_x) dx <= coordinate;
        if (ld_y) dy <= coordinate;
        if (ld_colour) dc <= colour_out;
        off <= off + 4'd1;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model(input [6:0] x, input [6:0] y, input [2:0] c);
        ex = x; ey = y; ecol = c;
        for (int i = 0; i < 16; i++) hits[i] = 0;
        stray = 0;
        pix_bad = 0;
    endtask

    task automatic check_model(input string tag);
        int once = 0;
        for (int i = 0; i < 16; i++) if (hits[i] == 1) once++;
        check({tag, "_pixels_once"}, once, 16);
        check({tag, "_stray"}, stray, 0);
        check({tag, "_pixel_colour"}, pix_bad, 0);
    endtask

    // one full request; optional go pokes during the sweep must be ignored
    task automatic request(input string tag, input [6:0] x, input [6:0] y, input [2:0] c,
                           input logic e, input [2:0] ec, input logic poke);
        int pc = 0, excl = 0, colbad = 0, n = 0, extra_done = 0;
        clear_model(x, y, ec);
        go = 1'b1; x_in = x; y_in = y; colour_in = c; erase = e;
        step();
        go = 1'b0;
        x_in = 7'd99; y_in = 7'd88; colour_in = 3'd5; erase = 1'b0;
        check({tag, "_ldx"}, ld_x, 1);
        check({tag, "_coord_x"}, coordinate, x);
        check({tag, "_busy"}, busy, 1);
        step();
        check({tag, "_ldy"}, ld_y, 1);
        check({tag, "_ldcol"}, ld_colour, 1);
        check({tag, "_coord_y"}, coordinate, y);
        check({tag, "_colour_ld"}, colour_out, ec);
        check({tag, "_ldx_off"}, ld_x, 0);
        while (n < 30 && !done) begin
            step();
            n++;
            if (poke) begin
                go = (n == 2 || n == 7);
                x_in = 7'd50;
            end
            if (plot) pc++;
            if (plot && (ld_x || ld_y || ld_colour)) excl++;
            if (plot && colour_out != ec) colbad++;
        end
        go = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_latency"}, n, 17);
        check({tag, "_plot_cycles"}, pc, 16);
        check({tag, "_exclusive"}, excl, 0);
        check({tag, "_colour_draw"}, colbad, 0);
        check_model(tag);
        step();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        if (poke) begin
            for (int i = 0; i < 25; i++) begin
                if (done) extra_done++;
                step();
            end
            check({tag, "_no_queued"}, extra_done, 0);
        end
    endtask

    initial begin
        int dn = 0, pc = 0, d1 = 0, d2 = 0, d3 = 0, bc = 0;
        #23;
        check("reset_busy", busy, 0);
        check("reset_plot", plot, 0);
        resetn = 1'b1;
        repeat (10) step();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_plot", plot, 0);
        check("idle_ldx", ld_x, 0);
        check("idle_ldy", ld_y, 0);
        check("idle_ldcol", ld_colour, 0);
        check("idle_coord", coordinate, 0);
        check("idle_colour", colour_out, 0);

        request("draw", 7'd20, 7'd35, 3'b100, 1'b0, 3'b100, 1'b0);
        repeat (3) step();
        request("erase", 7'd20, 7'd35, 3'b111, 1'b1, 3'b000, 1'b0);
        repeat (3) step();
        request("ignore", 7'd20, 7'd35, 3'b010, 1'b0, 3'b010, 1'b1);

        go = 1'b1; x_in = 7'd3; y_in = 7'd5; colour_in = 3'd2; erase = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (plot) pc++;
            if (done) begin
                dn++;
                if (dn == 1) d1 = i;
                if (dn == 2) d2 = i;
                if (dn == 3) d3 = i;
            end
        end
        go = 1'b0;
        check("b2b_dones", dn, 3);
        check("b2b_first", d1, 19);
        check("b2b_gap1", d2 - d1, 20);
        check("b2b_gap2", d3 - d2, 20);
        check("b2b_plot_total", pc, 48);
        repeat (3) step();

        go = 1'b1; x_in = 7'd10; y_in = 7'd10; colour_in = 3'd6;
        step();
        go = 1'b0;
        repeat (9) step();
        check("mid_plot_before", plot, 1);
        #2 resetn = 1'b0;
        #1;
        check("async_plot", plot, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_coord", coordinate, 0);
        check("async_colour", colour_out, 0);
        step();
        #3 resetn = 1'b1;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done) dn++;
            if (busy) bc++;
        end
        check("post_reset_done", dn, 0);
        check("post_reset_busy", bc, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
